// File: rtl/btb_pkg.sv
// Shared types, constants and helpers for the set-associative branch target buffer.
package btb_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_MIN   = 2'b00;
    localparam ctr_t CTR_RESET = 2'b01;
    localparam ctr_t CTR_ALLOC = 2'b10;
    localparam ctr_t CTR_MAX   = 2'b11;

    // Width of the per-set round-robin pointer; kept at 1 bit for a direct-mapped table.
    function automatic int unsigned rr_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Saturating 2-bit direction counter update.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? CTR_MAX : ctr_t'(ctr + 2'd1);
        end
        return (ctr == CTR_MIN) ? CTR_MIN : ctr_t'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/btb_assoc_victim_sel.sv
// Victim way selection for one set: lowest invalid way, otherwise the round-robin way.
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned RR_W = 1
) (
    input  logic [WAYS-1:0] i_valid,
    input  logic [RR_W-1:0] i_rr,
    output logic [RR_W-1:0] o_victim_c,
    output logic [RR_W-1:0] o_rr_next_c
);

    logic all_valid_c;

    // Scan from the top so the lowest invalid way wins; rr only moves on a true eviction.
    always_comb begin
        all_valid_c = &i_valid;
        o_victim_c  = i_rr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_victim_c = RR_W'(w);
            end
        end
        o_rr_next_c = (all_valid_c && (WAYS > 1)) ? RR_W'(i_rr + RR_W'(1)) : i_rr;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters, round-robin allocation and flush.
// Optional feature: define BTB_UPD_BYPASS_EN to forward a same-cycle update to a matching lookup.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned ENTRIES = 256,
    parameter int unsigned WAYS    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rd_en,
    input  logic [PC_W-1:0] i_rd_pc,
    output logic            o_rd_valid,
    output logic            o_hit,
    output logic            o_taken,
    output logic [PC_W-1:0] o_target,
    input  logic            i_upd_en,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [PC_W-1:0] i_upd_target,
    input  logic            i_flush
);

    localparam int unsigned SETS  = ENTRIES / WAYS;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam int unsigned RR_W  = rr_width(WAYS);

    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAYS-1:0]  valid_d  [SETS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [TAG_W-1:0] tag_d    [SETS][WAYS];
    logic [PC_W-1:0]  target_q [SETS][WAYS];
    logic [PC_W-1:0]  target_d [SETS][WAYS];
    ctr_t             ctr_q    [SETS][WAYS];
    ctr_t             ctr_d    [SETS][WAYS];
    logic [RR_W-1:0]  rr_q     [SETS];
    logic [RR_W-1:0]  rr_d     [SETS];

    logic            rd_valid_q, rd_valid_d;
    logic            hit_q, hit_d;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] out_target_q, out_target_d;

    logic [IDX_W-1:0] rd_idx, upd_idx;
    logic [TAG_W-1:0] rd_tag, upd_tag;
    logic             upd_hit_c;
    logic [RR_W-1:0]  upd_way_c;
    logic [RR_W-1:0]  victim_c;
    logic [RR_W-1:0]  rr_next_c;
    logic             rd_hit_c;
    logic             rd_taken_c;
    logic [PC_W-1:0]  rd_target_c;
    logic             unused_pc_lsb;

    assign rd_idx        = i_rd_pc[IDX_W+1:2];
    assign rd_tag        = i_rd_pc[PC_W-1:IDX_W+2];
    assign upd_idx       = i_upd_pc[IDX_W+1:2];
    assign upd_tag       = i_upd_pc[PC_W-1:IDX_W+2];
    assign unused_pc_lsb = ^{i_rd_pc[1:0], i_upd_pc[1:0]};

    btb_victim_sel #(
        .WAYS (WAYS),
        .RR_W (RR_W)
    ) u_victim_sel (
        .i_valid     (valid_q[upd_idx]),
        .i_rr        (rr_q[upd_idx]),
        .o_victim_c  (victim_c),
        .o_rr_next_c (rr_next_c)
    );

    // Find the way (if any) matching the update PC.
    always_comb begin
        upd_hit_c = 1'b0;
        upd_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_hit_c = 1'b1;
                upd_way_c = RR_W'(w);
            end
        end
    end

    // Next table state: flush wins over update; only a taken miss allocates.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        rr_d     = rr_q;
        if (i_flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
                rr_d[s]    = '0;
            end
        end else if (i_upd_en) begin
            if (upd_hit_c) begin
                ctr_d[upd_idx][upd_way_c] = ctr_next(ctr_q[upd_idx][upd_way_c], i_upd_taken);
                if (i_upd_taken) begin
                    target_d[upd_idx][upd_way_c] = i_upd_target;
                end
            end else if (i_upd_taken) begin
                valid_d[upd_idx][victim_c]  = 1'b1;
                tag_d[upd_idx][victim_c]    = upd_tag;
                target_d[upd_idx][victim_c] = i_upd_target;
                ctr_d[upd_idx][victim_c]    = CTR_ALLOC;
                rr_d[upd_idx]               = rr_next_c;
            end
        end
    end

`ifdef BTB_UPD_BYPASS_EN
    logic rd_byp_c;
    assign rd_byp_c = i_upd_en && i_rd_en && !i_flush &&
                      (upd_idx == rd_idx) && (upd_tag == rd_tag);
`endif

    // Lookup compare; with forwarding a matching same-cycle update is seen through the next state.
    always_comb begin
        rd_hit_c    = 1'b0;
        rd_taken_c  = 1'b0;
        rd_target_c = '0;
        for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_UPD_BYPASS_EN
            if (rd_byp_c && valid_d[rd_idx][w] && (tag_d[rd_idx][w] == rd_tag)) begin
                rd_hit_c    = 1'b1;
                rd_taken_c  = ctr_d[rd_idx][w][1];
                rd_target_c = target_d[rd_idx][w];
            end else if (!rd_byp_c && valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
`else
            if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
`endif
                rd_hit_c    = 1'b1;
                rd_taken_c  = ctr_q[rd_idx][w][1];
                rd_target_c = target_q[rd_idx][w];
            end
        end
    end

    // Result registers hold their value between requests.
    always_comb begin
        rd_valid_d   = i_rd_en;
        hit_d        = hit_q;
        taken_d      = taken_q;
        out_target_d = out_target_q;
        if (i_rd_en) begin
            hit_d        = rd_hit_c;
            taken_d      = rd_hit_c & rd_taken_c;
            out_target_d = rd_target_c;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= CTR_RESET;
                end
            end
            rd_valid_q   <= 1'b0;
            hit_q        <= 1'b0;
            taken_q      <= 1'b0;
            out_target_q <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            rr_q         <= rr_d;
            rd_valid_q   <= rd_valid_d;
            hit_q        <= hit_d;
            taken_q      <= taken_d;
            out_target_q <= out_target_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_hit      = hit_q;
    assign o_taken    = taken_q;
    assign o_target   = out_target_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc at default parameters (128 sets, index pc[8:2]).
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [31:0] rd_pc;
    logic        rd_valid;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;

    int n_cmp = 0;
    int n_bad = 0;

    btb_assoc dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rd_en      (rd_en),
        .i_rd_pc      (rd_pc),
        .o_rd_valid   (rd_valid),
        .o_hit        (hit),
        .o_taken      (taken),
        .o_target     (target),
        .i_upd_en     (upd_en),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target),
        .i_flush      (flush)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic v, input logic h, input logic t,
                          input logic [31:0] tgt);
        chk({tag, ".valid"},  {31'd0, rd_valid}, {31'd0, v});
        chk({tag, ".hit"},    {31'd0, hit},      {31'd0, h});
        chk({tag, ".taken"},  {31'd0, taken},    {31'd0, t});
        chk({tag, ".target"}, target,            tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        cyc();
        upd_en = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        rd_en = 1'b1; rd_pc = pc;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; rd_pc = '0; upd_en = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; flush = 1'b0;

        // Reset state and a cold miss
        do_reset();
        chk_rd("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h0000_1000);
        chk_rd("cold_miss", 1'b1, 1'b0, 1'b0, 32'h0);

        // Allocate, then lookup; idle cycle holds the result
        upd(32'h1000, 1'b1, 32'h2000);
        look(32'h1000);
        chk_rd("alloc_hit", 1'b1, 1'b1, 1'b1, 32'h2000);
        cyc();
        chk_rd("idle_hold", 1'b0, 1'b1, 1'b1, 32'h2000);

        // Not-taken updates: ctr 10->01->00, target kept
        upd(32'h1000, 1'b0, 32'h9999);
        upd(32'h1000, 1'b0, 32'h9999);
        look(32'h1000);
        chk_rd("nt_twice", 1'b1, 1'b1, 1'b0, 32'h2000);
        upd(32'h1000, 1'b0, 32'h9999);
        look(32'h1000);
        chk_rd("nt_floor", 1'b1, 1'b1, 1'b0, 32'h2000);

        // Four taken: 00->01->10->11->11; target overwritten
        for (int i = 0; i < 4; i++) upd(32'h1000, 1'b1, 32'h2400);
        look(32'h1000);
        chk_rd("t_sat", 1'b1, 1'b1, 1'b1, 32'h2400);
        upd(32'h1000, 1'b0, 32'h0);
        look(32'h1000);
        chk_rd("sat_minus1", 1'b1, 1'b1, 1'b1, 32'h2400);

        // Eviction in set 0
        do_reset();
        upd(32'h1000, 1'b1, 32'hA000);
        upd(32'h1200, 1'b1, 32'hA200);
        upd(32'h1400, 1'b1, 32'hA400);
        rd_en = 1'b1; rd_pc = 32'h1000;
        cyc();
        chk_rd("evict_1000", 1'b1, 1'b0, 1'b0, 32'h0);
        rd_pc = 32'h1200;
        cyc();
        chk_rd("keep_1200", 1'b1, 1'b1, 1'b1, 32'hA200);
        rd_pc = 32'h1400;
        cyc();
        rd_en = 1'b0;
        chk_rd("new_1400", 1'b1, 1'b1, 1'b1, 32'hA400);

        // Not-taken miss allocates nothing
        upd(32'h1800, 1'b0, 32'hA800);
        look(32'h1800);
        chk_rd("nt_miss", 1'b1, 1'b0, 1'b0, 32'h0);

        upd(32'h1600, 1'b1, 32'hA600);
        look(32'h1200);
        chk_rd("evict_1200", 1'b1, 1'b0, 1'b0, 32'h0);
        look(32'h1400);
        chk_rd("keep_1400", 1'b1, 1'b1, 1'b1, 32'hA400);
        look(32'h1600);
        chk_rd("new_1600", 1'b1, 1'b1, 1'b1, 32'hA600);

        // Same-cycle update and lookup (evicts 0x1400, rr -> 1)
        upd_en = 1'b1; upd_pc = 32'h3000; upd_taken = 1'b1; upd_target = 32'h4000;
        rd_en = 1'b1; rd_pc = 32'h3000;
        cyc();
        upd_en = 1'b0; rd_en = 1'b0;
`ifdef BTB_UPD_BYPASS_EN
        chk_rd("same_cyc", 1'b1, 1'b1, 1'b1, 32'h4000);
`else
        chk_rd("same_cyc", 1'b1, 1'b0, 1'b0, 32'h0);
`endif
        look(32'h3000);
        chk_rd("after_same", 1'b1, 1'b1, 1'b1, 32'h4000);

        // Flush with a same-cycle lookup (pre-flush view) and a dropped update
        flush = 1'b1; rd_en = 1'b1; rd_pc = 32'h1600;
        upd_en = 1'b1; upd_pc = 32'h5000; upd_taken = 1'b1; upd_target = 32'h5500;
        cyc();
        flush = 1'b0; rd_en = 1'b0; upd_en = 1'b0;
        chk_rd("flush_cyc", 1'b1, 1'b1, 1'b1, 32'hA600);
        look(32'h1600);
        chk_rd("flushed_1600", 1'b1, 1'b0, 1'b0, 32'h0);
        look(32'h3000);
        chk_rd("flushed_3000", 1'b1, 1'b0, 1'b0, 32'h0);
        look(32'h5000);
        chk_rd("flush_drop_upd", 1'b1, 1'b0, 1'b0, 32'h0);

        // rr cleared by flush: third allocation must evict way 0
        upd(32'h1000, 1'b1, 32'hB000);
        upd(32'h1200, 1'b1, 32'hB200);
        upd(32'h1400, 1'b1, 32'hB400);
        look(32'h1000);
        chk_rd("rr_clr_1000", 1'b1, 1'b0, 1'b0, 32'h0);
        look(32'h1200);
        chk_rd("rr_clr_1200", 1'b1, 1'b1, 1'b1, 32'hB200);

        // Reset beats an in-flight lookup
        rst = 1'b1; rd_en = 1'b1; rd_pc = 32'h1200;
        cyc();
        rst = 1'b0; rd_en = 1'b0;
        chk_rd("rst_rd", 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h1200);
        chk_rd("post_rst", 1'b1, 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage of the pipelined RISC-V core. It replaces the direct-mapped, always-taken BTB with WAYS-way sets and a per-entry 2-bit saturating direction counter. Allocation is round-robin per set, and a flush port clears the table. Lookups are registered; updates come from the execute stage on branch resolution.

## Interface
- PC_W, 32: PC width.
- ENTRIES, 256: total entries; power of two.
- WAYS, 2: associativity; one of 1, 2, 4. SETS = ENTRIES/WAYS, IDX_W = log2(SETS), TAG_W = PC_W-IDX_W-2.

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_rd_en  in  1  lookup request.
- i_rd_pc  in  PC_W  fetch PC to look up.
- o_rd_valid  out  1  lookup result valid (one cycle after i_rd_en).
- o_hit  out  1  tag match in a valid way.
- o_taken  out  1  predicted taken (o_hit & ctr[1]).
- o_target  out  PC_W  predicted target; 0 on miss.
- i_upd_en  in  1  resolved-branch update.
- i_upd_pc  in  PC_W  branch PC.
- i_upd_taken  in  1  resolved direction.
- i_upd_target  in  PC_W  resolved target.
- i_flush  in  1  invalidate whole table.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry state: valid, tag, target, 2-bit counter ctr. Per set: round-robin pointer rr (log2 WAYS bits; absent when WAYS=1).
- Lookup: compare all ways of the set. At most one way can match, because allocation happens only on a miss. Output the target and ctr of the matching way.
- Update hit, taken: ctr saturating +1 (max 2'b11); target overwritten with i_upd_target.
- Update hit, not taken: ctr saturating -1 (min 2'b00); target kept.
- Update miss, taken: allocate a victim way. Write valid=1, tag, target, and ctr=2'b10.
- Update miss, not taken: no state change.
- Victim selection: lowest-index invalid way. If every way is valid, use rr, and rr advances by 1 mod WAYS. rr does not change when an invalid way is chosen.
- Flush: all valid bits and rr pointers cleared. Tags, targets and ctrs are left unchanged. Flush beats a same-cycle update, which is dropped.
- Reset: valid=0, ctr=2'b01, rr=0, tag=0, target=0 everywhere. o_rd_valid=0, o_hit=0, o_taken=0, o_target=0. Reset beats flush, update and lookup; a lookup in flight when reset is asserted is discarded.

## Timing
- Lookup latency 1: i_rd_en at edge N produces o_* at N+1. o_rd_valid is high for exactly one cycle per request; back-to-back requests are supported, one per cycle.
- When i_rd_en=0, o_rd_valid=0 and o_hit, o_taken, o_target hold their previous values.
- An update is written at the edge of the cycle in which i_upd_en is asserted. Lookups issued in the next cycle see it.
- Update and lookup in the same cycle read pre-update state, unless the bypass below is compiled in.
- A lookup in the same cycle as i_flush reads pre-flush state. The flush is visible to lookups from the next cycle on.

## Configuration
- BTB_UPD_BYPASS_EN defined: when i_upd_en and i_rd_en are in the same cycle with equal index and tag, the lookup returns the post-update entry state. A taken miss therefore returns hit=1, ctr=2'b10, target=i_upd_target. A not-taken miss still returns a miss. The bypass is suppressed when i_flush is high.
- BTB_UPD_BYPASS_EN undefined: no forwarding; same-cycle lookups see pre-update state.

## Structure
- Package btb_pkg: ctr_t (2-bit); constants CTR_RESET=2'b01, CTR_ALLOC=2'b10, CTR_MAX=2'b11; function ctr_next(ctr_t, taken) implementing the saturating update.
- Sub-module btb_victim_sel: takes a set's valid vector and rr; produces the victim way and the next rr. Purely combinational, one instance.
- Table storage is flop arrays with synchronous clear, matching the existing BTB style.

## Test plan
All tests use the defaults (SETS=128, index pc[8:2], tag pc[31:9]).
- Reset, then lookup 0x0000_1000 -> next cycle o_rd_valid=1, o_hit=0, o_taken=0, o_target=0.
- Update 0x1000 taken, target 0x2000; lookup 0x1000 the cycle after -> o_hit=1, o_taken=1, o_target=0x2000.
- Then two not-taken updates of 0x1000 -> lookup gives o_hit=1, o_taken=0, o_target=0x2000. Then four taken updates -> ctr saturates at 2'b11, o_taken=1.
- From reset, taken updates to 0x1000, 0x1200, 0x1400 (same set, three tags) -> 0x1400 evicts way 0. Lookup 0x1000 misses; lookups 0x1200 and 0x1400 hit. A fourth, 0x1600, evicts 0x1200.
- Same-cycle taken update and lookup of 0x3000, target 0x4000 -> without macro o_hit=0; with macro o_hit=1, o_target=0x4000.
- i_flush after filling three entries -> all later lookups miss. Then assert i_rst in the same cycle as i_rd_en -> next cycle o_rd_valid=0 and all outputs are 0.
